// File: rtl/spi_frame_fifo.sv
// SPI frame receiver: deserializes fixed-length MSB-first frames from a
// clk-synchronous SPI bus and queues them in a first-word-fall-through FIFO.
module spi_frame_fifo #(
    parameter int unsigned NBYTES      = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SAMPLE_RISE = 1
) (
    input  logic                          clk,
    input  logic                          resetB,
    input  logic                          cs,
    input  logic                          sck,
    input  logic                          sdi,
    input  logic                          frame_ready,
    input  logic                          ovf_clr,
    output logic                          frame_valid,
    output logic [8*NBYTES-1:0]           frame_data,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned FW = 8 * NBYTES;
    localparam int unsigned CW = $clog2(FW + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          sck_q, sck_d;
    logic          cs_q, cs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] sr_q, sr_d;
    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          frame_valid_q, frame_valid_d;
    logic [FW-1:0] frame_data_q, frame_data_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;

    logic          sample_edge_c;
    logic          push_c;
    logic [FW-1:0] frame_c;
    logic          pop_c;
    logic          full_c;
    logic          accept_c;
    logic          drop_c;

    // Bit capture: edge detect, shift register, bit counter, frame completion.
    always_comb begin
        sck_d       = sck;
        cs_d        = cs;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        push_c      = 1'b0;
        frame_err_d = 1'b0;
        frame_c     = {sr_q[FW-2:0], sdi};
        sample_edge_c = (SAMPLE_RISE != 0) ? (sck & ~sck_q) : (~sck & sck_q);

        if (!cs) begin
            cnt_d = '0;
            if (cs_q && (cnt_q != '0)) begin
                frame_err_d = 1'b1;
            end
        end else if (sample_edge_c) begin
            sr_d = frame_c;
            if (cnt_q == CW'(FW - 1)) begin
                cnt_d  = '0;
                push_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // FIFO bookkeeping; head frame and valid are recomputed from next state.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        pop_c    = frame_valid_q & frame_ready;
        full_c   = (level_q == LW'(DEPTH));
        accept_c = push_c & (~full_c | pop_c);
        drop_c   = push_c & full_c & ~pop_c;

        if (accept_c) begin
            mem_d[wr_ptr_q] = frame_c;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(accept_c) - LW'(pop_c);

        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        frame_valid_d = (level_d != '0);
        frame_data_d  = mem_d[rd_ptr_d];
    end

    // State registers.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            sck_q         <= 1'b0;
            cs_q          <= 1'b0;
            cnt_q         <= '0;
            sr_q          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sck_q         <= sck_d;
            cs_q          <= cs_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;

endmodule
